pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the RV32I pipeline. It replaces the fixed load-always IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Adds valid/ready handshaking so stages can stall on memory responses, synchronous flush for branch/jump squash, and bubble (NOP) insertion.
- Has an optional 2-entry skid mode that registers the upstream ready, breaking the combinational ready chain across stages.
- Carries saturating stall and flush-drop counters for performance debugging.

Parameters:
WIDTH, 32, payload bits (packed control word + operands for the stage).
BUBBLE, {WIDTH{1'b0}} with low 32 bits = 32'h00000013, payload driven whenever no valid entry is presented (addi x0,x0,0).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream stage presents payload
in_ready  output  1  this register can accept payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream consumes payload this cycle
out_data  output  WIDTH  downstream payload (BUBBLE when out_valid=0)
flush  input  1  synchronous squash of all held entries
clr_count  input  1  synchronous clear of both counters
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
drop_count  output  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Reset (async, immediate): out_valid=0; out_data=BUBBLE; skid entry invalid; occupancy=0; stall_count=0; drop_count=0; in_ready=1 (subject to flush gating below).
- Accept: in_valid && in_ready && !flush at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Latency: payload accepted at edge t is on out_data with out_valid=1 after edge t (available to the downstream stage at edge t+1). There is no combinational in_data→out_data path.
- Ordering: strict FIFO; no payload is ever duplicated or reordered.
- SKID=1, entries main (drives out) and skid:
  - in_ready = !skid_valid && !flush. It is registered except for the flush gating term.
  - Accept while main is empty, or main is emitting and skid is empty: payload loads main.
  - Accept while main is held (not emitting): payload loads skid.
  - Main emits while skid is valid: skid moves to main and skid empties. Any simultaneous accept is impossible because in_ready=0.
  - Full (occupancy=2): in_ready=0. in_valid is ignored; upstream must hold.
- SKID=0:
  - Single entry; in_ready = (!out_valid || out_ready) && !flush.
  - Simultaneous emit and accept replaces the entry in one cycle (full throughput).
- Flush (priority over all data movement):
  - At the edge, both entries become invalid and out_data becomes BUBBLE.
  - An emit in the flush cycle is still a legal consume by downstream.
  - drop_count += entries valid at the edge minus 1 if out_ready was high with out_valid.
- Hold: with out_valid=1 and out_ready=0, out_data is stable every cycle until emitted or flushed.
- stall_count:
  - +1 at each edge where out_valid=1 and out_ready=0, flush cycles included.
  - Saturates at 2^CNT_W−1, no wrap.
- Counter clear: clr_count wins over a simultaneous increment (result 0). drop_count saturates identically.
- Reset asserted mid-transfer discards all entries; the first accept after deassertion behaves as from empty.
- in_data is sampled only on accept; X on in_data while in_valid=0 must not propagate to out_data.

Test Plan:
- Reset, then in_valid=1, in_data=0xA5, out_ready=1 for 1 cycle → next cycle out_valid=1, out_data=0xA5, occupancy=1; then out_valid=0, out_data=0x00000013.
- SKID=1: stream 0x1,0x2,0x3 with out_ready=0 from cycle 1 → occupancy reaches 2, in_ready=0, 0x3 held upstream. Release out_ready → output 0x1,0x2,0x3 on consecutive cycles, no gaps, no loss; stall_count=number of held cycles.
- SKID=0 back-to-back: in_valid=out_ready=1 for 8 cycles, data 0..7 → output 0..7 one per cycle after 1-cycle latency; in_ready stays 1.
- Flush with occupancy=2, out_ready=0 → next cycle occupancy=0, out_valid=0, out_data=BUBBLE, drop_count=2. Flush concurrent with in_valid=1 → in_ready=0 and payload not captured.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles → stall_count=15. Then clr_count together with a stall cycle → 0.
- Assert rst asynchronously mid-cycle with occupancy=2 → out_valid drops before the next clock edge; counters 0; in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, bubble output, optional skid entry and perf counters
module pipe_stage_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(32'h0000_0013),
    parameter bit               SKID   = 1'b1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             clr_count,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] drop_count
);
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d, drop_q, drop_d;
    logic [CNT_W:0]   stall_sum, drop_sum;
    logic [1:0]       drop_n;
    logic             emit, main_free, accept;

    assign emit      = main_v_q & out_ready;
    assign main_free = !main_v_q | emit;
    // Skid mode decouples in_ready from out_ready; only flush gates it combinationally
    assign in_ready  = (SKID ? !skid_v_q : main_free) & !flush;
    assign accept    = in_valid & in_ready;

    assign out_valid   = main_v_q;
    assign out_data    = main_v_q ? main_q : BUBBLE;
    assign occupancy   = {skid_v_q, main_v_q & !skid_v_q};
    assign stall_count = stall_q;
    assign drop_count  = drop_q;

    // Data movement: flush squashes everything, skid refills main before any new accept
    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (main_free) begin
            main_v_d = skid_v_q | accept;
            main_d   = skid_v_q ? skid_q : accept ? in_data : main_q;
            skid_v_d = 1'b0;
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
        end
    end

    // Saturating counters; an entry emitted during flush was consumed, not dropped
    always_comb begin
        drop_n    = flush ? ({1'b0, main_v_q} + {1'b0, skid_v_q} - {1'b0, emit}) : 2'd0;
        stall_sum = {1'b0, stall_q} + (CNT_W+1)'(main_v_q & !out_ready);
        drop_sum  = {1'b0, drop_q} + (CNT_W+1)'(drop_n);
        stall_d   = clr_count ? '0 : stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
        drop_d    = clr_count ? '0 : drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // State registers with asynchronous reset to the empty state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= BUBBLE;
            skid_q   <= '0;
            stall_q  <= '0;
            drop_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            drop_q   <= drop_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid (A) and single-entry 4-bit-counter (B) configurations
module tb_pipe_stage_reg;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_iv = 0, a_ir, a_ov, a_or = 0, a_fl = 0, a_clr = 0;
    logic [31:0] a_id = 0, a_od;
    logic [1:0]  a_occ;
    logic [15:0] a_st, a_dr;

    logic        b_iv = 0, b_ir, b_ov, b_or = 0, b_fl = 0, b_clr = 0;
    logic [31:0] b_id = 0, b_od;
    logic [1:0]  b_occ;
    logic [3:0]  b_st, b_dr;

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl),
        .clr_count(a_clr), .occupancy(a_occ), .stall_count(a_st), .drop_count(a_dr));

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl),
        .clr_count(b_clr), .occupancy(b_occ), .stall_count(b_st), .drop_count(b_dr));

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_a_ov", 64'(a_ov), 64'd0);
        chk("rst_a_od", 64'(a_od), 64'h13);
        chk("rst_a_occ", 64'(a_occ), 64'd0);
        chk("rst_a_ir", 64'(a_ir), 64'd1);
        chk("rst_a_cnt", 64'({a_st, a_dr}), 64'd0);
        step();
        rst = 1'b0;

        a_iv = 1; a_id = 32'hA5; a_or = 1;
        step();
        chk("single_ov", 64'(a_ov), 64'd1);
        chk("single_od", 64'(a_od), 64'hA5);
        chk("single_occ", 64'(a_occ), 64'd1);
        a_iv = 0;
        step();
        chk("single_ov_after", 64'(a_ov), 64'd0);
        chk("single_bubble", 64'(a_od), 64'h13);
        chk("single_occ_after", 64'(a_occ), 64'd0);

        a_or = 0; a_iv = 1; a_id = 32'h1;
        step();
        chk("skid_occ1", 64'(a_occ), 64'd1);
        chk("skid_ir1", 64'(a_ir), 64'd1);
        a_id = 32'h2;
        step();
        chk("skid_occ2", 64'(a_occ), 64'd2);
        chk("skid_ir0", 64'(a_ir), 64'd0);
        a_id = 32'h3;
        step();
        chk("skid_full_occ", 64'(a_occ), 64'd2);
        chk("skid_full_od", 64'(a_od), 64'h1);
        chk("skid_stall2", 64'(a_st), 64'd2);
        a_or = 1;
        step();
        chk("drain_od2", 64'(a_od), 64'h2);
        chk("drain_occ1", 64'(a_occ), 64'd1);
        chk("drain_ir1", 64'(a_ir), 64'd1);
        step();
        chk("drain_od3", 64'(a_od), 64'h3);
        chk("drain_ov3", 64'(a_ov), 64'd1);
        a_iv = 0;
        step();
        chk("drain_empty", 64'(a_ov), 64'd0);
        chk("drain_stall", 64'(a_st), 64'd2);

        a_or = 0; a_iv = 1; a_id = 32'h10;
        step();
        a_id = 32'h11;
        step();
        chk("fl_pre_occ", 64'(a_occ), 64'd2);
        a_fl = 1; a_id = 32'h12;
        #1;
        chk("fl_ir_gated", 64'(a_ir), 64'd0);
        step();
        chk("fl_occ", 64'(a_occ), 64'd0);
        chk("fl_ov", 64'(a_ov), 64'd0);
        chk("fl_od", 64'(a_od), 64'h13);
        chk("fl_drop2", 64'(a_dr), 64'd2);
        chk("fl_stall", 64'(a_st), 64'd4);
        a_fl = 0; a_iv = 0;
        step();
        chk("fl_not_captured", 64'(a_ov), 64'd0);

        a_iv = 1; a_id = 32'h20; a_or = 1;
        step();
        a_iv = 0; a_fl = 1;
        step();
        chk("fl_emit_nodrop", 64'(a_dr), 64'd2);
        chk("fl_emit_ov", 64'(a_ov), 64'd0);
        a_fl = 0;

        b_iv = 1; b_or = 1;
        for (int i = 0; i < 8; i++) begin
            b_id = 32'(i);
            #1;
            chk("b2b_ir", 64'(b_ir), 64'd1);
            step();
            chk("b2b_od", 64'(b_od), 64'(i));
            chk("b2b_ov", 64'(b_ov), 64'd1);
        end
        b_iv = 0; b_id = 'x;
        step();
        chk("b_x_ov", 64'(b_ov), 64'd0);
        chk("b_x_bubble", 64'(b_od), 64'h13);

        b_iv = 1; b_id = 32'h55; b_or = 0;
        step();
        chk("b_hold_ir", 64'(b_ir), 64'd0);
        b_iv = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("b_hold_od", 64'(b_od), 64'h55);
        end
        chk("b_sat", 64'(b_st), 64'd15);
        b_clr = 1;
        step();
        chk("b_clr_wins", 64'(b_st), 64'd0);
        b_clr = 0;
        step();
        chk("b_after_clr", 64'(b_st), 64'd1);
        chk("b_occ", 64'(b_occ), 64'd1);

        a_or = 0; a_iv = 1; a_id = 32'h30;
        step();
        a_id = 32'h31;
        step();
        chk("ar_pre_occ", 64'(a_occ), 64'd2);
        a_iv = 0;
        #2 rst = 1'b1;
        #1;
        chk("ar_ov", 64'(a_ov), 64'd0);
        chk("ar_occ", 64'(a_occ), 64'd0);
        chk("ar_ir", 64'(a_ir), 64'd1);
        chk("ar_cnt", 64'({a_st, a_dr}), 64'd0);
        chk("ar_b_cnt", 64'({b_st, b_dr}), 64'd0);
        step();
        rst = 1'b0;
        a_iv = 1; a_id = 32'h40; a_or = 1;
        step();
        chk("ar_first_od", 64'(a_od), 64'h40);
        chk("ar_first_occ", 64'(a_occ), 64'd1);
        a_iv = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
